// File: rtl/sync_fifo_pkg.sv
// sync_fifo shared definitions.
// Default geometry and the per-edge queue operation type.
package sync_fifo_pkg;

  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_BOTH
  } fifo_op_e;

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo port bundle.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
);

  logic                     i_write;
  logic [WIDTH-1:0]         i_wdata;
  logic                     i_read;
  logic [WIDTH-1:0]         o_rdata;
  logic                     o_empty;
  logic                     o_almost_full;
  logic [$clog2(DEPTH):0]   o_queued;

  modport master (
    output i_write,
    output i_wdata,
    output i_read,
    input  o_rdata,
    input  o_empty,
    input  o_almost_full,
    input  o_queued
  );

  modport slave (
    input  i_write,
    input  i_wdata,
    input  i_read,
    output o_rdata,
    output o_empty,
    output o_almost_full,
    output o_queued
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo storage: DEPTH x WIDTH simple dual-port RAM.
// Synchronous write port, registered read port (read reg resets to 0).
module sync_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q = '0;

  always_ff @(posedge i_clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data.
// Pointers, count and flags live here; storage is sync_fifo_ram.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic       i_clock,
  input  logic       i_reset,
  sync_fifo_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] wr_ptr = '0;
  logic [PW-1:0] rd_ptr = '0;
  logic [CW-1:0] count  = '0;

  logic     do_wr;
  logic     do_rd;
  fifo_op_e op;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_wr = bus.i_write && (count < FULL);
  assign do_rd = bus.i_read && (count != '0);

  always_comb begin
    op = OP_NONE;
    unique case (1'b1)
      (do_wr && do_rd):  op = OP_BOTH;
      (do_wr && !do_rd): op = OP_PUSH;
      (!do_wr && do_rd): op = OP_POP;
      default:           op = OP_NONE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_rd) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case (op)
        OP_PUSH: count <= count + 1'b1;
        OP_POP:  count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flag one entry early so a producer with a
  // registered view of it cannot overflow.
  assign bus.o_empty       = (count == '0);
  assign bus.o_almost_full = (count >= FULL - 1'b1);
  assign bus.o_queued      = count;

  sync_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (PW)
  ) u_ram (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .we      (do_wr),
    .waddr   (wr_ptr),
    .wdata   (bus.i_wdata),
    .re      (do_rd),
    .raddr   (rd_ptr),
    .rdata   (bus.o_rdata)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// sync_fifo bench: vector table, hand sequences
// and a queue scoreboard for FIFO order.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_if #(.DEPTH(16), .WIDTH(8)) bus ();

  sync_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    int         q;
    logic [7:0] rd;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];
  logic [7:0] mrd = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d,
                      input logic r);
    bit aw;
    bit ar;
    aw = w && (sb.size() < 16);
    ar = r && (sb.size() > 0);
    bus.i_write = w;
    bus.i_wdata = d;
    bus.i_read  = r;
    @(posedge clk);
    #1;
    bus.i_write = 1'b0;
    bus.i_read  = 1'b0;
    if (ar) mrd = sb.pop_front();
    if (aw) sb.push_back(d);
    chk("queued", int'(bus.o_queued), sb.size());
    chk("empty", int'(bus.o_empty), int'(sb.size() == 0));
    chk("afull", int'(bus.o_almost_full), int'(sb.size() >= 15));
    chk("rdata", int'(bus.o_rdata), int'(mrd));
  endtask

  task automatic do_reset(input logic w);
    rst = 1'b1;
    bus.i_write = w;
    bus.i_wdata = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_write = 1'b0;
    sb.delete();
    mrd = 8'h00;
  endtask

  vec_t tv[7];

  initial begin
    bus.i_write = 1'b0;
    bus.i_wdata = 8'h00;
    bus.i_read  = 1'b0;

    tv[0] = '{w:1'b0, d:8'h00, r:1'b1, q:0, rd:8'h00};
    tv[1] = '{w:1'b1, d:8'hA5, r:1'b0, q:1, rd:8'h00};
    tv[2] = '{w:1'b0, d:8'h00, r:1'b1, q:0, rd:8'hA5};
    tv[3] = '{w:1'b0, d:8'h00, r:1'b0, q:0, rd:8'hA5};
    tv[4] = '{w:1'b0, d:8'h00, r:1'b0, q:0, rd:8'hA5};
    tv[5] = '{w:1'b1, d:8'h11, r:1'b1, q:1, rd:8'hA5};
    tv[6] = '{w:1'b0, d:8'h00, r:1'b1, q:0, rd:8'h11};

    do_reset(1'b0);
    chk("rst_q", int'(bus.o_queued), 0);
    chk("rst_empty", int'(bus.o_empty), 1);
    chk("rst_afull", int'(bus.o_almost_full), 0);
    chk("rst_rdata", int'(bus.o_rdata), 0);

    for (int i = 0; i < 7; i++) begin
      step(tv[i].w, tv[i].d, tv[i].r);
      chk("tv_q", int'(bus.o_queued), tv[i].q);
      chk("tv_empty", int'(bus.o_empty), int'(tv[i].q == 0));
      chk("tv_rd", int'(bus.o_rdata), int'(tv[i].rd));
    end

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_af", int'(bus.o_almost_full), int'(i >= 14));
    end
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_q", int'(bus.o_queued), 16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain", int'(bus.o_rdata), i);
    end

    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b1, 8'h30, 1'b1);
    chk("rw5_q", int'(bus.o_queued), 5);
    chk("rw5_rd", int'(bus.o_rdata), 8'h20);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    chk("rw5_last", int'(bus.o_rdata), 8'h30);

    step(1'b1, 8'h40, 1'b1);
    chk("rw0_q", int'(bus.o_queued), 1);
    chk("rw0_rd", int'(bus.o_rdata), 8'h30);
    step(1'b0, 8'h00, 1'b1);
    chk("rw0_out", int'(bus.o_rdata), 8'h40);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    chk("rw16_q", int'(bus.o_queued), 15);
    chk("rw16_rd", int'(bus.o_rdata), 8'h50);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    chk("rw16_last", int'(bus.o_rdata), 8'h5F);
    chk("rw16_empty", int'(bus.o_empty), 1);

    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h80 + i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("wrap_q", int'(bus.o_queued), 3);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("wrap_last", int'(bus.o_rdata), 8'hA7);

    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    do_reset(1'b1);
    chk("mid_q", int'(bus.o_queued), 0);
    chk("mid_empty", int'(bus.o_empty), 1);
    chk("mid_rd", int'(bus.o_rdata), 0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("mid_new", int'(bus.o_rdata), 8'h3C);
    chk("mid_end_q", int'(bus.o_queued), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
